instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_if.sv | 34 +++
 rtl/instr_loader.sv | 167 ++++++++++++++++
 tb/tb_instr_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Shared types and the upstream instruction handshake interface for instr_loader.
// The master drives an instruction; the slave (the loader) answers with in_ready.
package instr_loader_pkg;
    typedef logic [3:0]         opcode_t;
    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    localparam opcode_t OP_ZERO = 4'h0;
    localparam opcode_t OP_ADD  = 4'h1;
    localparam opcode_t OP_SUB  = 4'h2;
    localparam opcode_t OP_MUL  = 4'h3;
    localparam opcode_t OP_DIV  = 4'h4;
    localparam opcode_t OP_MOD  = 4'h5;
endpackage

interface instr_loader_if;
    import instr_loader_pkg::*;

    logic     in_valid;
    logic     in_ready;
    opcode_t  in_opcode;
    operand_t in_operand_a;
    operand_t in_operand_b;

    modport master (
        output in_valid, in_opcode, in_operand_a, in_operand_b,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_operand_a, in_operand_b,
        output in_ready
    );
endinterface

// File: rtl/instr_loader.sv
// Buffers instructions in a small FIFO and issues them to an instruction register.
// Optional: define LOADER_DIV_ZERO_DROP_EN to discard DIV/MOD entries whose operand B is zero.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int START_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    instr_loader_if.slave   in_if,
    input  logic            run,
    output logic            load_en,
    output opcode_t         opcode,
    output operand_t        operand_a,
    output operand_t        operand_b,
    output address_t        write_pointer,
    output logic [5:0]      loaded_count,
    output logic            wrapped,
    output logic            drop_pulse
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    opcode_t  fifo_op [FIFO_DEPTH];
    operand_t fifo_a  [FIFO_DEPTH];
    operand_t fifo_b  [FIFO_DEPTH];

    state_t          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic            load_en_q, load_en_d;
    opcode_t         opcode_q, opcode_d;
    operand_t        operand_a_q, operand_a_d;
    operand_t        operand_b_q, operand_b_d;
    address_t        wp_q, wp_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            wrapped_q, wrapped_d;
`ifdef LOADER_DIV_ZERO_DROP_EN
    logic            drop_q, drop_d;
`endif

    logic     push, pop, fifo_empty, drop;
    opcode_t  head_op;
    operand_t head_a, head_b;

    always_comb begin
        fifo_empty = (count_q == '0);
        push       = in_if.in_valid && in_ready_q;
        pop        = (state_q == ISSUE) && !fifo_empty && run;
        head_op    = fifo_op[rd_ptr_q];
        head_a     = fifo_a[rd_ptr_q];
        head_b     = fifo_b[rd_ptr_q];
`ifdef LOADER_DIV_ZERO_DROP_EN
        drop       = pop && ((head_op == OP_DIV) || (head_op == OP_MOD)) && (head_b == 32'sd0);
`else
        drop       = 1'b0;
`endif

        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        opcode_d    = opcode_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        wp_d        = wp_q;
        cnt_d       = cnt_q;
        wrapped_d   = wrapped_q;

        case (state_q)
            IDLE:    if (!fifo_empty && run) state_d = ISSUE;
            ISSUE: begin
                if (fifo_empty)      state_d = IDLE;
                else if (!run)       state_d = HOLD;
            end
            HOLD:    if (run) state_d = ISSUE;
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d    = count_q + CW'(push) - CW'(pop);
        // Registered from the next occupancy, so a full FIFO never accepts
        // in the same cycle it frees a slot.
        in_ready_d = (count_d != CW'(FIFO_DEPTH));

        load_en_d = pop && !drop;
        if (load_en_d) begin
            opcode_d    = head_op;
            operand_a_d = head_a;
            operand_b_d = head_b;
        end
`ifdef LOADER_DIV_ZERO_DROP_EN
        drop_d = drop;
`endif

        // The pointer names the load currently on the outputs, then moves on.
        if (load_en_q) begin
            wp_d = wp_q + 5'd1;
            if (wp_q == 5'd31) wrapped_d = 1'b1;
            if (cnt_q != 6'd32) cnt_d = cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            load_en_q   <= 1'b0;
            opcode_q    <= OP_ZERO;
            operand_a_q <= '0;
            operand_b_q <= '0;
            wp_q        <= address_t'(START_ADDR);
            cnt_q       <= '0;
            wrapped_q   <= 1'b0;
`ifdef LOADER_DIV_ZERO_DROP_EN
            drop_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            load_en_q   <= load_en_d;
            opcode_q    <= opcode_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            wp_q        <= wp_d;
            cnt_q       <= cnt_d;
            wrapped_q   <= wrapped_d;
`ifdef LOADER_DIV_ZERO_DROP_EN
            drop_q      <= drop_d;
`endif
        end
    end

    // Storage carries no reset; flushing is done by clearing the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr_q] <= in_if.in_opcode;
            fifo_a[wr_ptr_q]  <= in_if.in_operand_a;
            fifo_b[wr_ptr_q]  <= in_if.in_operand_b;
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign load_en        = load_en_q;
    assign opcode         = opcode_q;
    assign operand_a      = operand_a_q;
    assign operand_b      = operand_b_q;
    assign write_pointer  = wp_q;
    assign loaded_count   = cnt_q;
    assign wrapped        = wrapped_q;
`ifdef LOADER_DIV_ZERO_DROP_EN
    assign drop_pulse     = drop_q;
`else
    assign drop_pulse     = 1'b0;
`endif
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a queue of expected loads plus an address/count model
// is checked on every cycle, alongside hand-computed checks for each scenario.
module tb_instr_loader;
    import instr_loader_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    always #5 clk = ~clk;

    instr_loader_if vif();

    logic       load_en, wrapped, drop_pulse;
    opcode_t    opcode;
    operand_t   operand_a, operand_b;
    address_t   write_pointer;
    logic [5:0] loaded_count;

    instr_loader #(.FIFO_DEPTH(4), .START_ADDR(0)) dut (
        .clk(clk), .reset(reset), .in_if(vif), .run(run),
        .load_en(load_en), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
        .write_pointer(write_pointer), .loaded_count(loaded_count),
        .wrapped(wrapped), .drop_pulse(drop_pulse)
    );

    typedef struct {opcode_t op; operand_t a; operand_t b;} item_t;
    item_t sb[$];
    item_t last_item = '{OP_ZERO, 32'sd0, 32'sd0};
    int    total = 0, bad = 0;
    int    n_loads = 0, n_drops = 0, last_wp = 0;
    int    exp_wp = 0, exp_cnt = 0;
    bit    exp_wrap = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_drop(input opcode_t op, input operand_t b);
`ifdef LOADER_DIV_ZERO_DROP_EN
        return ((op == OP_DIV) || (op == OP_MOD)) && (b == 32'sd0);
`else
        return 1'b0;
`endif
    endfunction

    // Per-cycle compare against the expected-load queue and address/count model.
    always @(negedge clk) begin
        item_t e;
        if (!reset) begin
`ifdef LOADER_DIV_ZERO_DROP_EN
            if (drop_pulse) n_drops++;
`else
            chk("drop_tied", {31'd0, drop_pulse}, 32'd0);
`endif
            if (load_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_load", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("load_opcode", {28'd0, opcode}, {28'd0, e.op});
                    chk("load_a", operand_a, e.a);
                    chk("load_b", operand_b, e.b);
                    chk("load_wp", {27'd0, write_pointer}, exp_wp);
                    chk("load_cnt", {26'd0, loaded_count}, exp_cnt);
                    chk("load_wrapped", {31'd0, wrapped}, {31'd0, exp_wrap});
                    $display("load %0d: op=%0h a=%0d b=%0d wp=%0d cnt=%0d", n_loads, opcode,
                             operand_a, operand_b, write_pointer, loaded_count);
                    last_item = e;
                    last_wp   = write_pointer;
                    n_loads++;
                    if (exp_wp == 31) exp_wrap = 1'b1;
                    exp_wp = (exp_wp + 1) % 32;
                    if (exp_cnt < 32) exp_cnt++;
                end
            end else begin
                chk("hold_opcode", {28'd0, opcode}, {28'd0, last_item.op});
                chk("hold_a", operand_a, last_item.a);
                chk("hold_b", operand_b, last_item.b);
                chk("idle_wp", {27'd0, write_pointer}, exp_wp);
                chk("idle_cnt", {26'd0, loaded_count}, exp_cnt);
            end
        end
    end

    task automatic clear_model();
        sb.delete();
        last_item = '{OP_ZERO, 32'sd0, 32'sd0};
        exp_wp = 0; exp_cnt = 0; exp_wrap = 1'b0;
    endtask

    task automatic do_reset();
        vif.in_valid = 1'b0;
        run = 1'b0;
        reset = 1'b1;
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high on return (1 time unit after the accepting edge).
    task automatic push(input opcode_t op, input operand_t a, input operand_t b);
        bit r;
        r = 1'b0;
        vif.in_valid = 1'b1;
        vif.in_opcode = op;
        vif.in_operand_a = a;
        vif.in_operand_b = b;
        for (int i = 0; i < 50 && !r; i++) begin
            @(negedge clk);
            r = vif.in_ready;
            @(posedge clk);
        end
        if (!r) chk("push_timeout", 32'd0, 32'd1);
        else if (!is_drop(op, b)) sb.push_back('{op, a, b});
        #1;
    endtask

    task automatic wait_loads(input int target, input int budget);
        int i;
        for (i = 0; i < budget && n_loads < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (n_loads < target) chk("load_timeout", n_loads, target);
    endtask

    task automatic wait_load_en(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = load_en;
        end
        if (!seen) chk(name, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dbase;
        vif.in_valid = 1'b0;
        vif.in_opcode = OP_ZERO;
        vif.in_operand_a = '0;
        vif.in_operand_b = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_load_en", {31'd0, load_en}, 32'd0);
        chk("rst_in_ready", {31'd0, vif.in_ready}, 32'd0);
        chk("rst_wp", {27'd0, write_pointer}, 32'd0);
        chk("rst_cnt", {26'd0, loaded_count}, 32'd0);
        chk("rst_wrapped", {31'd0, wrapped}, 32'd0);
        chk("rst_opcode", {28'd0, opcode}, 32'd0);
        chk("rst_a", operand_a, 32'd0);
        chk("rst_b", operand_b, 32'd0);
        chk("rst_drop", {31'd0, drop_pulse}, 32'd0);
        reset = 1'b0;
        #1 chk("ready_before_edge", {31'd0, vif.in_ready}, 32'd0);
        @(posedge clk);
        #1 chk("ready_after_reset", {31'd0, vif.in_ready}, 32'd1);

        // Basic load and latency
        run = 1'b1;
        push(OP_ADD, 32'sd5, 32'sd3);
        vif.in_valid = 1'b0;
        @(negedge clk) chk("lat_k1", {31'd0, load_en}, 32'd0);
        @(negedge clk) chk("lat_k2", {31'd0, load_en}, 32'd0);
        @(negedge clk);
        chk("lat_k3", {31'd0, load_en}, 32'd1);
        chk("basic_wp", {27'd0, write_pointer}, 32'd0);
        chk("basic_op", {28'd0, opcode}, {28'd0, OP_ADD});
        chk("basic_a", operand_a, 32'd5);
        chk("basic_b", operand_b, 32'd3);
        @(negedge clk);
        chk("basic_single", {31'd0, load_en}, 32'd0);
        chk("basic_cnt", {26'd0, loaded_count}, 32'd1);

        // Full FIFO, then drain in order
        do_reset();
        for (int i = 0; i < 4; i++) push(OP_MUL, i + 1, i + 10);
        vif.in_valid = 1'b0;
        @(negedge clk);
        chk("full_ready_low", {31'd0, vif.in_ready}, 32'd0);
        run = 1'b1;
        wait_load_en("full_no_load");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("full_burst_en", {31'd0, load_en}, 32'd1);
            chk("full_burst_wp", {27'd0, write_pointer}, i);
            chk("full_burst_a", operand_a, i + 1);
        end
        @(negedge clk);
        chk("full_done", {31'd0, load_en}, 32'd0);
        chk("ready_restored", {31'd0, vif.in_ready}, 32'd1);

        // HOLD mid-burst
        do_reset();
        base = n_loads;
        run = 1'b1;
        push(OP_SUB, 32'sd100, 32'sd1);
        push(OP_SUB, 32'sd200, 32'sd2);
        push(OP_SUB, 32'sd300, 32'sd3);
        run = 1'b0;
        vif.in_valid = 1'b0;
        @(negedge clk) chk("hold_first", {31'd0, load_en}, 32'd1);
        repeat (4) begin
            @(negedge clk) chk("hold_stopped", {31'd0, load_en}, 32'd0);
        end
        run = 1'b1;
        wait_loads(base + 3, 20);
        repeat (2) @(negedge clk);
        chk("hold_last_a", last_item.a, 32'd300);
        chk("hold_cnt", {26'd0, loaded_count}, 32'd3);

        // Reset mid-burst
        do_reset();
        push(OP_SUB, 32'sd7, 32'sd1);
        push(OP_SUB, 32'sd8, 32'sd2);
        vif.in_valid = 1'b0;
        run = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 chk("mid_load_on", {31'd0, load_en}, 32'd1);
        reset = 1'b1;
        clear_model();
        #1;
        chk("async_load_en", {31'd0, load_en}, 32'd0);
        chk("async_wp", {27'd0, write_pointer}, 32'd0);
        chk("async_ready", {31'd0, vif.in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        base = n_loads;
        repeat (8) @(negedge clk);
        #1;
        chk("no_stale", n_loads, base);
        chk("stale_wp", {27'd0, write_pointer}, 32'd0);

        // Pointer wrap and count saturation
        do_reset();
        base = n_loads;
        run = 1'b1;
        for (int i = 0; i < 33; i++) push(OP_ADD, i, -i);
        vif.in_valid = 1'b0;
        wait_loads(base + 33, 100);
        chk("wrap_last_wp", last_wp, 32'd0);
        chk("wrap_flag", {31'd0, wrapped}, 32'd1);
        chk("wrap_cnt", {26'd0, loaded_count}, 32'd32);
        @(negedge clk);
        chk("wrap_sat", {26'd0, loaded_count}, 32'd32);

        // Divide by zero
        do_reset();
        base = n_loads;
        dbase = n_drops;
        run = 1'b1;
        push(OP_DIV, 32'sd9, 32'sd0);
        push(OP_SUB, 32'sd9, 32'sd4);
        vif.in_valid = 1'b0;
`ifdef LOADER_DIV_ZERO_DROP_EN
        wait_loads(base + 1, 20);
        repeat (2) @(negedge clk);
        #1;
        chk("div_drops", n_drops - dbase, 32'd1);
        chk("div_sub_wp", last_wp, 32'd0);
        chk("div_cnt", {26'd0, loaded_count}, 32'd1);
`else
        wait_loads(base + 2, 20);
        repeat (2) @(negedge clk);
        #1;
        chk("div_drops", n_drops - dbase, 32'd0);
        chk("div_sub_wp", last_wp, 32'd1);
        chk("div_cnt", {26'd0, loaded_count}, 32'd2);
`endif
        chk("div_last_op", {28'd0, opcode}, {28'd0, OP_SUB});
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
